conway_grid_serial_v5: RTL
==========================

Name: conway_grid_serial_v5

Overview:
- Parametrised W×H Conway's Game of Life engine with a serial load/dump interface and an autonomous multi-generation run controller.
- Successor to the fixed 8x8 serial top:
  - arbitrary grid size
  - optional toroidal wrap
  - valid-qualified serial I/O with exact bit counting, so there is no multiple-of-N read restriction
  - non-destructive rotating dump
  - run-N-generations with early stop on a stable pattern
- Sits between the board-level serial pins and debug LEDs.

Parameters:
- GRID_WIDTH, 8, columns per row (≥3)
- GRID_HEIGHT, 8, rows (≥3)
- WRAP, 0, 0 = cells outside the grid are dead; 1 = toroidal edges
- GEN_W, 16, width of the generation count and elapsed counters

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- MODE  in  2  00 = load, 01 = run, 10 = dump, 11 = hold
- DATA_IN  in  1  serial cell bit
- DIN_VALID  in  1  DATA_IN is sampled this cycle
- START  in  1  single-cycle pulse; begins a run when MODE = 01
- GEN_COUNT  in  GEN_W  generations to run; latched on START
- DATA_OUT  out  1  serial cell bit
- DOUT_VALID  out  1  DATA_OUT is meaningful this cycle
- BUSY  out  1  a run or dump is in progress
- DONE  out  1  one-cycle pulse at the end of a run or dump
- STABLE  out  1  last computed generation equalled its predecessor
- GEN_ELAPSED  out  GEN_W  generations computed in the current/last run
- LOAD_FULL  out  1  exactly N = W·H bits received since load entry

Behaviour:
- Cell index i = row·W + col; N = W·H.
- Next-state rule is B3/S23: a dead cell with 3 live neighbours is born; a live cell with 2–3 live neighbours survives.
- Neighbour indices:
  - WRAP = 0: out-of-range neighbours read 0.
  - WRAP = 1: indices taken modulo W and H.
- Reset (synchronous): grid = 0, FSM = IDLE, all counters 0, every output 0.
- FSM states: IDLE, LOAD, RUN, DUMP, FIN.
- IDLE:
  - MODE = 00 → LOAD (bit counter cleared).
  - MODE = 01 with START → RUN (GEN_COUNT latched, GEN_ELAPSED = 0, STABLE = 0).
  - MODE = 10 → DUMP.
  - MODE = 11 → stay.
- LOAD:
  - Each cycle with DIN_VALID: grid ← {grid[N-2:0], DATA_IN}; the first bit received ends at index N-1.
  - The bit counter saturates at N; LOAD_FULL = (count == N).
  - Bits arriving after full are still shifted in (the oldest bit is dropped) and the counter stays at N.
  - MODE ≠ 00 → IDLE. The grid keeps whatever was shifted in; a partial load is not undone.
- RUN:
  - BUSY = 1.
  - Each cycle: grid ← next(grid), GEN_ELAPSED += 1, STABLE ← (next == grid).
  - Exit to FIN when GEN_ELAPSED reaches the latched count, or when STABLE would be set. A stable exit still counts that generation.
  - Latched count 0: the grid is untouched, and the FSM goes to FIN next cycle with DONE.
  - MODE leaving 01 mid-run aborts to IDLE: no DONE, grid keeps the last generation, GEN_ELAPSED holds.
  - START while RUN is ignored.
- DUMP:
  - BUSY = 1.
  - Each cycle: DATA_OUT = grid[N-1], DOUT_VALID = 1, and grid rotates left by 1.
  - Exactly N cycles, then FIN. After the dump the grid is bit-identical to the pre-dump grid.
  - Leaving MODE 10 early → IDLE. The grid is left partially rotated; software must finish with a fresh load.
- FIN:
  - DONE = 1 for one cycle, BUSY = 0, then IDLE.
  - A new operation requires MODE to pass through IDLE decoding, so the mode must be held or changed by the host.
- Outputs are registered: DATA_OUT/DOUT_VALID appear the cycle after DUMP entry.
- RESET mid-operation wins over every other input.
- Counter widths:
  - The GEN_ELAPSED increment saturates at 2^GEN_W−1.
  - The bit counter is $clog2(N+1) bits wide.

Decomposition:
- Package conway_pkg:
  - mode enum (MODE_LOAD, MODE_RUN, MODE_DUMP, MODE_HOLD)
  - FSM state enum
  - function cell_idx(row, col) with wrap handling
- One combinational sub-module, conway_next_state, parametrised by GRID_WIDTH, GRID_HEIGHT and WRAP: grid in, next grid out.
- FSM, shift/rotate datapath and counters stay in the top.

Test Plan:
1. 8x8, WRAP = 0: load a blinker at cells 27, 28, 29 (horizontal, row 3); RUN with GEN_COUNT = 1, then dump → live bits at 20, 28, 36 only; GEN_ELAPSED = 1; DONE pulses once; 64 DOUT_VALID cycles.
2. Same blinker, GEN_COUNT = 10 → run completes after 10 cycles, STABLE = 0, dumped grid equals the original horizontal blinker.
3. 2x2 block at cells 0, 1, 8, 9, GEN_COUNT = 100 → stops after 1 generation, STABLE = 1, GEN_ELAPSED = 1, grid unchanged.
4. WRAP = 1, 8x8, glider near the bottom-right corner, GEN_COUNT = 32 → dumped grid equals the initial glider (full torus traversal in 4·8 generations).
5. Dump twice back-to-back → both 64-bit streams are identical; LOAD after 70 bits → LOAD_FULL = 1, grid holds the last 64 bits.
6. Assert RESET during cycle 5 of a GEN_COUNT = 20 run → next cycle grid = 0, BUSY = 0, GEN_ELAPSED = 0, no DONE. Separately, drop MODE mid-run → abort, no DONE, GEN_ELAPSED holds.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and helpers for the Game of Life engine.
//   mode_e   : host MODE encoding
//   state_e  : top-level controller states
//   cell_idx : flat cell index of (row, col), -1 when off-grid without wrap
package conway_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_DUMP = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // Row/col may be one step outside the grid; wrap folds them back onto the torus.
  function automatic int cell_idx(input int row, input int col,
                                  input int width, input int height,
                                  input bit wrap);
    int r;
    int c;
    r = row;
    c = col;
    if (wrap) begin
      r = (row + height) % height;
      c = (col + width) % width;
    end else if (row < 0 || row >= height || col < 0 || col >= width) begin
      return -1;
    end
    return r * width + c;
  endfunction

endpackage

// File: rtl/conway_next_state.sv
// Combinational B3/S23 successor of a whole grid.
//   grid_i : current generation, cell i = row*GRID_WIDTH + col
//   next_o : next generation, same layout
module conway_next_state
  import conway_pkg::*;
#(
  parameter int unsigned GRID_WIDTH  = 8,
  parameter int unsigned GRID_HEIGHT = 8,
  parameter int unsigned WRAP        = 0
) (
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid_i,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_o
);

  logic [3:0] live_cnt;
  int         nb;

  // Count the eight neighbours of every cell and apply birth-on-3 / survive-on-2-or-3.
  always_comb begin
    next_o   = '0;
    live_cnt = '0;
    nb       = 0;
    for (int r = 0; r < int'(GRID_HEIGHT); r++) begin
      for (int c = 0; c < int'(GRID_WIDTH); c++) begin
        live_cnt = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              nb = cell_idx(r + dr, c + dc, int'(GRID_WIDTH), int'(GRID_HEIGHT), WRAP != 0);
              if (nb >= 0) live_cnt = live_cnt + 4'(grid_i[nb]);
            end
          end
        end
        next_o[r*int'(GRID_WIDTH) + c] = (live_cnt == 4'd3) ||
                                         (grid_i[r*int'(GRID_WIDTH) + c] && live_cnt == 4'd2);
      end
    end
  end

endmodule

// File: rtl/conway_grid_serial_v5.sv
// W x H Game of Life engine with serial load/dump and a multi-generation run controller.
//   CLK, RESET        : clock, synchronous active-high reset
//   MODE              : 00 load, 01 run, 10 dump, 11 hold
//   DATA_IN/DIN_VALID : serial load bit and its qualifier
//   START/GEN_COUNT   : run request and generation budget (latched on START)
//   DATA_OUT/DOUT_VALID : serial dump bit and its qualifier (registered)
//   BUSY/DONE         : operation in progress / one-cycle completion pulse
//   STABLE            : last computed generation equalled its predecessor
//   GEN_ELAPSED       : generations computed in the current/last run
//   LOAD_FULL         : exactly W*H bits received since load entry
module conway_grid_serial_v5
  import conway_pkg::*;
#(
  parameter int unsigned GRID_WIDTH  = 8,
  parameter int unsigned GRID_HEIGHT = 8,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned GEN_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       MODE,
  input  logic             DATA_IN,
  input  logic             DIN_VALID,
  input  logic             START,
  input  logic [GEN_W-1:0] GEN_COUNT,
  output logic             DATA_OUT,
  output logic             DOUT_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             STABLE,
  output logic [GEN_W-1:0] GEN_ELAPSED,
  output logic             LOAD_FULL
);

  localparam int unsigned      N       = GRID_WIDTH * GRID_HEIGHT;
  localparam int unsigned      CNT_W   = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  state_e             state_q, state_d;
  logic [N-1:0]       grid_q, grid_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   dump_cnt_q, dump_cnt_d;
  logic [GEN_W-1:0]   gen_target_q, gen_target_d;
  logic [GEN_W-1:0]   gen_elapsed_q, gen_elapsed_d;
  logic               stable_q, stable_d;
  logic               dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load_full_q, load_full_d;

  mode_e              mode;
  logic [N-1:0]       next_grid;
  logic [GEN_W-1:0]   gen_inc;
  logic               gen_same;
  logic               run_zero;
  logic               run_last;
  logic               dump_last;

  assign mode = mode_e'(MODE);

  conway_next_state #(
    .GRID_WIDTH (GRID_WIDTH),
    .GRID_HEIGHT(GRID_HEIGHT),
    .WRAP       (WRAP)
  ) u_next (
    .grid_i(grid_q),
    .next_o(next_grid)
  );

  // Run/dump termination terms shared by the next-state and output logic.
  assign gen_inc   = (gen_elapsed_q == GEN_MAX) ? gen_elapsed_q : gen_elapsed_q + GEN_W'(1);
  assign gen_same  = (next_grid == grid_q);
  assign run_zero  = (gen_elapsed_q == gen_target_q);
  assign run_last  = run_zero || (gen_inc == gen_target_q) || gen_same;
  assign dump_last = (dump_cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        case (mode)
          MODE_LOAD: state_d = ST_LOAD;
          MODE_RUN:  if (START) state_d = ST_RUN;
          MODE_DUMP: state_d = ST_DUMP;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_LOAD: if (mode != MODE_LOAD) state_d = ST_IDLE;
      ST_RUN: begin
        if (mode != MODE_RUN) state_d = ST_IDLE;
        else if (run_last)    state_d = ST_FIN;
      end
      ST_DUMP: begin
        if (mode != MODE_DUMP) state_d = ST_IDLE;
        else if (dump_last)    state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, counters and registered outputs.
  always_comb begin
    grid_d        = grid_q;
    bit_cnt_d     = bit_cnt_q;
    dump_cnt_d    = dump_cnt_q;
    gen_target_d  = gen_target_q;
    gen_elapsed_d = gen_elapsed_q;
    stable_d      = stable_q;
    dout_d        = 1'b0;
    dout_valid_d  = 1'b0;
    busy_d        = (state_d == ST_RUN) || (state_d == ST_DUMP);
    done_d        = (state_d == ST_FIN);
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_LOAD) bit_cnt_d = '0;
        if (mode == MODE_DUMP) dump_cnt_d = '0;
        if (mode == MODE_RUN && START) begin
          gen_target_d  = GEN_COUNT;
          gen_elapsed_d = '0;
          stable_d      = 1'b0;
        end
      end
      ST_LOAD: begin
        if (mode == MODE_LOAD && DIN_VALID) begin
          grid_d = {grid_q[N-2:0], DATA_IN};
          if (bit_cnt_q != N_CNT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // A zero budget leaves the grid untouched and only passes through FIN.
        if (mode == MODE_RUN && !run_zero) begin
          grid_d        = next_grid;
          gen_elapsed_d = gen_inc;
          stable_d      = gen_same;
        end
      end
      ST_DUMP: begin
        // Rotation means N steps restore the original grid.
        if (mode == MODE_DUMP) begin
          dout_d       = grid_q[N-1];
          dout_valid_d = 1'b1;
          grid_d       = {grid_q[N-2:0], grid_q[N-1]};
          dump_cnt_d   = dump_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    load_full_d = (bit_cnt_d == N_CNT);
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      grid_q        <= '0;
      bit_cnt_q     <= '0;
      dump_cnt_q    <= '0;
      gen_target_q  <= '0;
      gen_elapsed_q <= '0;
      stable_q      <= 1'b0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_full_q   <= 1'b0;
    end else begin
      grid_q        <= grid_d;
      bit_cnt_q     <= bit_cnt_d;
      dump_cnt_q    <= dump_cnt_d;
      gen_target_q  <= gen_target_d;
      gen_elapsed_q <= gen_elapsed_d;
      stable_q      <= stable_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_full_q   <= load_full_d;
    end
  end

  assign DATA_OUT    = dout_q;
  assign DOUT_VALID  = dout_valid_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign STABLE      = stable_q;
  assign GEN_ELAPSED = gen_elapsed_q;
  assign LOAD_FULL   = load_full_q;

endmodule
